demux_8_32_buf: RTL
===================

# demux_8_32_buf

Buffered 1-to-8 demultiplexer for 32-bit results in the dynamic pipeline. It accepts a (select, data) word on a single valid/ready input port and delivers it to exactly one of eight destination ports, each with its own valid/ready handshake. It is the distribution counterpart of the 8:1 source selector: the selector gathers one of eight sources onto a bus, and this block fans a bus word back out to eight consumers. It sits between the result bus and the per-unit (reservation-station/register-file slot) input latches. An internal FIFO decouples producer and consumer stalls.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2
- DATA_W, 32: payload width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset; synchronous, active-low
- flush  in  1  synchronous discard of all buffered entries
- in_valid  in  1  producer offers word
- in_ready  out  1  block can accept word
- in_sel  in  3  destination port index 0..7
- in_data  in  DATA_W  payload
- out_valid  out  8  one-hot; bit k means port k's word is on out_data
- out_ready  in  8  per-port consumer ready
- out_data  out  DATA_W  shared payload bus to all ports
- count  out  $clog2(DEPTH)+1  current occupancy 0..DEPTH

## Operation
- Push: in_valid & in_ready at the rising edge writes {in_sel, in_data} at the tail.
- Pop: out_valid[k] & out_ready[k] at the rising edge, where k is the head select, removes the head. out_ready bits of the other ports are ignored.
- in_ready = (count != DEPTH). There is no pass-through when full. A push is refused in a full cycle even if a pop occurs in that cycle.
- Head presentation: when count>0, out_valid = 1<<head_sel and out_data = head_data. When count==0, out_valid=8'b0 and out_data=0. The bus is never driven to z or x.
- Occupancy states:
  - EMPTY (count==0)
  - PARTIAL (0<count<DEPTH)
  - FULL (count==DEPTH)
- State transitions:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle (only possible in PARTIAL): count unchanged, both pointers advance
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- Priority: rst_n low > flush > push/pop.
  - flush high: count←0 and pointers←0. A push or pop in the same cycle is discarded.
  - Storage contents are not cleared by reset or flush; only the pointers and count are.
- Words are delivered strictly in arrival order. A stalled head (out_ready[head_sel]=0) blocks every later word, even words for other ports. There is no reordering.

## Timing
- Reset values, with rst_n sampled low at an edge:
  - count=0, in_ready=1, out_valid=0, out_data=0
  - pointers=0
- Latency: a word pushed at edge t is visible on out_valid/out_data after edge t, i.e. in cycle t+1. Minimum input-to-consumption is 1 cycle.
- Throughput: 1 word/cycle sustained when the consumer is always ready.
- in_ready, out_valid and out_data are functions of registered state only. There is no combinational path from out_ready or in_valid to any output.
- Reset mid-operation: all buffered words are lost. Outputs reach reset values in the cycle after the reset edge.
- Flush behaves identically to reset, except that it is a functional input.

## Structure
- Package demux_pkg holds:
  - NPORT=8
  - SEL_W=3
  - default DATA_W=32
  - the entry typedef {sel[SEL_W-1:0], data[DATA_W-1:0]}
- Sub-module sync_fifo: a generic DEPTH×width circular buffer with push, pop, flush and count, clocked by clk with the same synchronous active-low reset. The top level adds one-hot decode of head_sel, zeroing of out_data when empty, and pop qualification by out_ready[head_sel].

## Test plan
- Reset, then push sel=5, data=0xDEADBEEF with out_ready=8'hFF:
  - cycle t+1: out_valid=8'b0010_0000, out_data=0xDEADBEEF
  - next cycle: count=0 and out_valid=0
- Fill with out_ready=0, pushing sel 0,1,2,3 with data 0x10..0x13:
  - count reaches 4 and in_ready=0
  - a 5th push is refused
  - raise out_ready=8'h0F: 0x10..0x13 appear in order on ports 0..3, one per cycle
- Head-of-line blocking: push sel=2 then sel=6 with out_ready=8'b0100_0000:
  - out_valid stays 8'b0000_0100 and count stays 2 indefinitely
  - setting out_ready[2] releases both words in order
- Simultaneous push and pop at count=2: count stays 2 and data order is preserved. Run 20 pushes to exercise pointer wrap and check all 20 words in order.
- Full-cycle pop with in_valid high: the pop occurs, the push is refused, count=3, in_ready=1 next cycle.
- flush (and separately rst_n=0) with count=3 and push and pop asserted in the same cycle:
  - next cycle: count=0, out_valid=0, out_data=0, in_ready=1

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants, types and helpers for the buffered 1-to-8 result demultiplexer.
package demux_pkg;

  localparam int NPORT          = 8;
  localparam int SEL_W          = 3;
  localparam int DEFAULT_DATA_W = 32;

  // One buffered word: destination port index plus its payload.
  typedef struct packed {
    logic [SEL_W-1:0]          sel;
    logic [DEFAULT_DATA_W-1:0] data;
  } entry_t;

  // Coarse occupancy classification of the buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  // One-hot decode of a destination index onto the per-port valid vector.
  function automatic logic [NPORT-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NPORT-1:0] vec;
    vec      = '0;
    vec[sel] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic DEPTH x WIDTH circular buffer with push, pop, flush and occupancy count.
// Storage is never cleared; only the pointers and the count are reset/flushed.
module sync_fifo
  import demux_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 35,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  occ_e             occ;
  logic             push_ok;
  logic             pop_ok;

  // Classify occupancy from the registered count; full/empty follow from it.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    occ = OCC_PARTIAL;
    if (count_q == '0)
      occ = OCC_EMPTY;
    else if (count_q == CNT_W'(DEPTH))
      occ = OCC_FULL;
  end

  assign full  = (occ == OCC_FULL);
  assign empty = (occ == OCC_EMPTY);

  // A push is refused whenever full, even if a pop happens in the same cycle;
  // flush discards both operations.
  assign push_ok = push & ~full  & ~flush;
  assign pop_ok  = pop  & ~empty & ~flush;

  // Next-state for pointers and count; flush returns everything to zero.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write at the tail on an accepted push.
  // NOTE: the storage array has no reset; stale words are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/demux_8_32_buf.sv
// Buffered 1-to-8 demultiplexer: accepts (sel, data) words on one valid/ready port,
// queues them in arrival order and presents the head word to exactly one of eight
// consumer ports. A stalled head blocks all later words regardless of destination.
module demux_8_32_buf
  import demux_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = DEFAULT_DATA_W,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic [NPORT-1:0]  out_valid,
  input  logic [NPORT-1:0]  out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } word_t;

  localparam int WORD_W = $bits(word_t);

  word_t head;
  word_t tail;
  logic  fifo_full;
  logic  fifo_empty;
  logic  push;
  logic  pop;

  assign tail     = '{sel: in_sel, data: in_data};
  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata (tail),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Present the head on its port only; drive a clean zero bus when empty so
  // consumers never see stale storage contents.
  always_comb begin
    out_valid = '0;
    out_data  = '0;
    pop       = 1'b0;
    if (!fifo_empty) begin
      out_valid = sel_onehot(head.sel);
      out_data  = head.data;
      pop       = out_ready[head.sel];
    end
  end

endmodule
